wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter_pkg.sv | 10 +
 rtl/wb_result_fifo.sv | 59 +++++
 rtl/wb_port_arbiter.sv | 69 ++++++
 tb/tb_wb_port_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, arbiter FSM states and the write-request record.
package wb_port_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  typedef enum logic {NORMAL, FORCE} arb_state_e;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wdata;
  } wr_req_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: parked long-latency results with per-entry valid bits and rd-match squash.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wr_req_t                    push_req,
  input  logic                       pop,
  input  logic                       squash,
  input  logic [REG_ADDR_W-1:0]      squash_rd,
  output wr_req_t                    head_req,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  wr_req_t            mem_q   [DEPTH];
  wr_req_t            mem_d   [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  assign head_req   = mem_q[rd_ptr_q];
  assign head_valid = vld_q[rd_ptr_q] & |cnt_q;
  assign occupancy  = cnt_q;
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++)
      if (squash && mem_q[i].rd == squash_rd) vld_d[i] = 1'b0;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = push_req;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between core writeback and a long-latency unit.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_we,
  input  logic [REG_ADDR_W-1:0]   core_rd,
  input  logic [XLEN-1:0]         core_wdata,
  input  logic                    lu_valid,
  output logic                    lu_ready,
  input  logic [REG_ADDR_W-1:0]   lu_rd,
  input  logic [XLEN-1:0]         lu_wdata,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_rd,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    core_stall,
  output logic [$clog2(DEPTH):0]  occupancy
);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_use, accept, occ_nz, head_valid, head_blk, drain, pop, bypass, push;
  wr_req_t          head_req;
  assign core_stall = (state_q == FORCE);
  always_comb begin
    core_use = ~rst & core_we & |core_rd & ~core_stall;
    lu_ready = ~rst & (occupancy < OCC_W'(DEPTH));
    accept   = lu_valid & lu_ready;
    occ_nz   = |occupancy;
    head_blk = head_valid & core_use;
    drain    = ~rst & head_valid & ~core_use;
    // squashed heads are discarded even while the core owns the port
    pop      = drain | (~rst & occ_nz & ~head_valid);
    bypass   = ~rst & ~core_use & ~occ_nz & accept & |lu_rd;
    push     = accept & |lu_rd & ~bypass & ~(core_use & lu_rd == core_rd);
    rf_we    = core_use | drain | bypass;
    rf_rd    = core_use ? core_rd : drain ? head_req.rd : bypass ? lu_rd : '0;
    rf_wdata = core_use ? core_wdata : drain ? head_req.wdata : bypass ? lu_wdata : '0;
    state_d  = (state_q == NORMAL && head_blk && cnt_q == CNT_W'(STARVE_LIMIT - 1)) ? FORCE : NORMAL;
    cnt_d    = (state_q == FORCE || state_d == FORCE || pop || !occ_nz) ? '0 :
               head_blk ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_req   ('{rd: lu_rd, wdata: lu_wdata}),
    .pop        (pop),
    .squash     (core_use),
    .squash_rd  (core_rd),
    .head_req   (head_req),
    .head_valid (head_valid),
    .occupancy  (occupancy)
  );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scoreboard bench for the writeback port arbiter.
module tb_wb_port_arbiter;
  logic        clk = 0, rst = 1;
  logic        core_we = 0, lu_valid = 0;
  logic [4:0]  core_rd = 0, lu_rd = 0;
  logic [31:0] core_wdata = 0, lu_wdata = 0;
  logic        lu_ready, rf_we, core_stall;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [1:0]  occupancy;
  logic [36:0] expq[$];
  logic [31:0] shadow[32];
  int          n_asrt = 0, n_fail = 0;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst), .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wdata(lu_wdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .core_stall(core_stall),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic cwe, input logic [4:0] crd, input logic [31:0] cd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    core_we = cwe; core_rd = crd; core_wdata = cd;
    lu_valid = lv; lu_rd = lrd; lu_wdata = ld;
  endtask

  task automatic tick();
    logic [36:0] e;
    @(negedge clk);
    if (rf_we) begin
      shadow[rf_rd] = rf_wdata;
      n_asrt++;
      assert (expq.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: got rd=%0d data=%0h expected no write", rf_rd, rf_wdata);
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rf_write", {27'd0, rf_rd, rf_wdata}, {27'd0, e});
      end
    end else
      chk("idle_zero", {27'd0, rf_rd, rf_wdata}, 64'd0);
    chk("missing_write", 64'(expq.size()), 64'd0);
    expq.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    @(posedge clk); #1;
    tick();
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_stall", core_stall, 0);
    rst = 0; #1;
    chk("idle_lu_ready", lu_ready, 1);
    tick();
    // 1: bypass into the port when the buffer is empty
    drive(0, 0, 0, 1, 5, 32'h1234);
    expq.push_back({5'd5, 32'h1234});
    tick();
    chk("t1_occ", occupancy, 0);
    // 2: core owns the port, LU results park, then drain in order
    drive(1, 3, 32'h300, 1, 7, 32'h70);
    expq.push_back({5'd3, 32'h300});
    tick();
    chk("t2_occ1", occupancy, 1);
    drive(1, 3, 32'h301, 1, 8, 32'h80);
    expq.push_back({5'd3, 32'h301});
    tick();
    chk("t2_occ2", occupancy, 2);
    chk("t2_full_ready", lu_ready, 0);
    drive(1, 3, 32'h302, 0, 0, 0);
    expq.push_back({5'd3, 32'h302});
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expq.push_back({5'd7, 32'h70});
    tick();
    chk("t2_occ_drain1", occupancy, 1);
    expq.push_back({5'd8, 32'h80});
    tick();
    chk("t2_occ_drain0", occupancy, 0);
    chk("t2_ready", lu_ready, 1);
    // 3: younger core write squashes a parked entry
    drive(1, 1, 32'h11, 1, 9, 32'hA);
    expq.push_back({5'd1, 32'h11});
    tick();
    chk("t3_occ1", occupancy, 1);
    drive(1, 9, 32'hB, 0, 0, 0);
    expq.push_back({5'd9, 32'hB});
    tick();
    chk("t3_occ_squashed", occupancy, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_occ_popped", occupancy, 0);
    chk("t3_reg9", shadow[9], 32'hB);
    // 4: same-rd collision with an empty buffer drops the LU result
    drive(1, 4, 32'h44, 1, 4, 32'h4A);
    expq.push_back({5'd4, 32'h44});
    tick();
    chk("t4_occ", occupancy, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t4_reg4", shadow[4], 32'h44);
    // 5: starvation forces a one-cycle stall and drain
    drive(1, 3, 32'h500, 1, 7, 32'h77);
    expq.push_back({5'd3, 32'h500});
    tick();
    chk("t5_occ", occupancy, 1);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 3, 32'h500 + i, 0, 0, 0);
      expq.push_back({5'd3, 32'h500 + 32'(i)});
      chk("t5_no_stall", core_stall, 0);
      tick();
    end
    chk("t5_stall", core_stall, 1);
    drive(1, 3, 32'h5FF, 0, 0, 0);
    expq.push_back({5'd7, 32'h77});
    tick();
    chk("t5_stall_clear", core_stall, 0);
    chk("t5_occ0", occupancy, 0);
    drive(1, 3, 32'h600, 0, 0, 0);
    expq.push_back({5'd3, 32'h600});
    tick();
    // 6: reset while full discards the buffer
    drive(1, 3, 32'h610, 1, 10, 32'hA0);
    expq.push_back({5'd3, 32'h610});
    tick();
    drive(1, 3, 32'h611, 1, 11, 32'hB0);
    expq.push_back({5'd3, 32'h611});
    tick();
    chk("t6_full", occupancy, 2);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1;
    tick();
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_ready", lu_ready, 0);
    rst = 0; #1;
    chk("t6_ready", lu_ready, 1);
    tick();
    chk("t6_occ_after", occupancy, 0);
    chk("t6_stall_after", core_stall, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
